uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- Receive-side controller placed between the uart_rx datapath and the host/register interface.
- Buffers completed frames in a small FIFO and drives hardware flow control to the far end from the FIFO fill level.
- Applies parity configuration to the receiver only between frames, and tracks overrun and frame-error status.

Parameters:
- UART_SIZE, 8, data bits per frame; must match the receiver.
- FIFO_DEPTH, 16, entries; power of two, at least 4.
- HIGH_WATER, 12, level at or above which flow control stops the remote sender.
- LOW_WATER, 4, level at or below which flow control releases; must satisfy LOW_WATER < HIGH_WATER < FIFO_DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_valid  in  1  one-cycle pulse from the receiver when a frame completes.
- frame_data  in  UART_SIZE  received data; qualified by frame_valid.
- frame_parity_err  in  1  parity error for this frame; qualified by frame_valid.
- frame_stop_err  in  1  stop-bit error for this frame; qualified by frame_valid.
- rx_busy  in  1  receiver not in IDLE.
- rx_parity_enable  out  1  parity enable driven to the receiver.
- rx_parity_type  out  1  parity type driven to the receiver (0 odd, 1 even).
- cfg_we  in  1  configuration write strobe.
- cfg_parity_enable  in  1  requested parity enable.
- cfg_parity_type  in  1  requested parity type.
- cfg_pending  out  1  a configuration write is waiting to be applied.
- rts_out  out  1  flow control to the remote end; 1 = clear to send.
- rd_en  in  1  pop request.
- rd_data  out  UART_SIZE  head-of-FIFO data.
- rd_perr  out  1  head entry had a parity error.
- rd_valid  out  1  FIFO not empty.
- level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overrun_err  out  1  sticky; a frame arrived while the FIFO was full.
- framing_err  out  1  sticky; a frame with a stop error was received.
- clr_err  in  1  clears the sticky flags and the counters.
- parity_err_cnt  out  16  saturating count of parity-error frames.
- stop_err_cnt  out  16  saturating count of stop-error frames.

Behaviour:
- Reset values: FIFO empty, level=0, rd_valid=0, rd_data=0, rd_perr=0, rts_out=0, rx_parity_enable=0, rx_parity_type=0, cfg_pending=0, overrun_err=0, framing_err=0, both counters 0, flow FSM in THROTTLE.
- rts_out goes to 1 on the first clock after reset is released (THROTTLE->ACCEPT, since level=0 <= LOW_WATER).
- Push rules on frame_valid:
  - frame_stop_err=1: frame is dropped and framing_err is set.
  - frame_stop_err=0 and FIFO not full: write {frame_parity_err, frame_data}.
  - FIFO full: frame is dropped and overrun_err is set.
- Pop: rd_en while rd_valid removes the head entry. rd_en on an empty FIFO is ignored and raises no error.
- Read latency: rd_data/rd_perr show the head entry combinationally from the FIFO and update on the cycle after a pop.
- Simultaneous push and pop:
  - FIFO not full: both take effect and level is unchanged.
  - FIFO full: the pop frees space, so the push succeeds and no overrun is flagged.
- Flow FSM, evaluated on the registered level after the cycle's push/pop:
  - ACCEPT: rts_out=1; move to THROTTLE when level >= HIGH_WATER.
  - THROTTLE: rts_out=0; move to ACCEPT when level <= LOW_WATER.
  - rts_out is a registered output, changing one cycle after the threshold crossing.
- Configuration:
  - cfg_we captures the requested values into shadow registers and sets cfg_pending.
  - When cfg_pending=1 and rx_busy=0, the shadow values are copied to rx_parity_* and cfg_pending clears in the same cycle.
  - A cfg_we in the apply cycle wins: the new values are shadowed and cfg_pending stays set.
  - Configuration never changes while rx_busy=1.
- Counters: increment on frame_valid with the matching error bit, saturate at 16'hFFFF, and still count when the frame is dropped.
- clr_err: clears the sticky flags and counters. If an error arrives in the same cycle as clr_err, the new error wins: flag=1, count=1.
- Wrap-around: pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty come from the MSB comparison.
- Reset asserted mid-frame: all state is cleared immediately and queued data is discarded.

Optional Feature:
- Macro UART_RX_CTRL_KEEP_BAD_EN.
- Defined:
  - Frames with stop errors are queued with a widened entry {stop_err, parity_err, data}.
  - An extra output rd_serr (1 bit) is added; framing_err and stop_err_cnt still update.
- Undefined:
  - Stop-error frames are dropped as above and rd_serr does not exist.

Decomposition:
- Package uart_pkg:
  - typedef enum {THROTTLE, ACCEPT} flow_state_t.
  - struct uart_cfg_t {parity_enable, parity_type}.
  - Localparam CNT_W=16.
- Sub-module uart_sync_fifo, parameterized by width and depth, providing push, pop, full, empty and level.
- The controller instantiates uart_sync_fifo and contains the flow FSM, config shadowing and error logic.

Test Plan:
- Push 3 frames (0xA5, 0x3C, 0xFF) with no errors, then pop 3 -> rd_data 0xA5, 0x3C, 0xFF in order; level 3->0; rd_valid falls after the third pop.
- Push 12 frames with no pops -> rts_out=0 one cycle after level=12; pop 8 -> rts_out=1 one cycle after level=4.
- Fill to 16, push 0x55 -> overrun_err=1, level stays 16; push 0x55 and pop in the same cycle at full -> no overrun, level=16, 0x55 is the tail entry.
- cfg_we with parity_enable=1, type=1 while rx_busy=1 -> rx_parity_* unchanged and cfg_pending=1; drop rx_busy -> rx_parity_enable=1, rx_parity_type=1, cfg_pending=0 the next cycle.
- 2 frames with parity error, 1 with stop error -> parity_err_cnt=2, stop_err_cnt=1, framing_err=1, level=2 with rd_perr=1; clr_err together with a new parity error -> parity_err_cnt=1.
- Assert reset mid-fill at level=7 -> level=0, rts_out=0, flags clear; release reset -> rts_out=1 one cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive-side controller.
package uart_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        THROTTLE = 1'b0,
        ACCEPT   = 1'b1
    } flow_state_t;

    typedef struct packed {
        logic parity_enable;
        logic parity_type;
    } uart_cfg_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is presented combinationally.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full/empty decode and push/pop qualification; a pop at full makes room for a push.
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_ok_s  = pop && !empty_s;
        push_ok_s = push && (!full_s || pop_ok_s);
        if (empty_s) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are unreachable while empty so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign level = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: frame FIFO, RTS flow control, deferred parity config, error status.
// Optional macro UART_RX_CTRL_KEEP_BAD_EN queues stop-error frames and adds rd_serr.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int UART_SIZE  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_valid,
    input  logic [UART_SIZE-1:0]          frame_data,
    input  logic                          frame_parity_err,
    input  logic                          frame_stop_err,
    input  logic                          rx_busy,
    output logic                          rx_parity_enable,
    output logic                          rx_parity_type,
    input  logic                          cfg_we,
    input  logic                          cfg_parity_enable,
    input  logic                          cfg_parity_type,
    output logic                          cfg_pending,
    output logic                          rts_out,
    input  logic                          rd_en,
    output logic [UART_SIZE-1:0]          rd_data,
    output logic                          rd_perr,
`ifdef UART_RX_CTRL_KEEP_BAD_EN
    output logic                          rd_serr,
`endif
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun_err,
    output logic                          framing_err,
    input  logic                          clr_err,
    output logic [CNT_W-1:0]              parity_err_cnt,
    output logic [CNT_W-1:0]              stop_err_cnt
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_CTRL_KEEP_BAD_EN
    localparam int ENTRY_W = UART_SIZE + 2;
`else
    localparam int ENTRY_W = UART_SIZE + 1;
`endif
    localparam logic [LVL_W-1:0] HIGH_LVL = LVL_W'(HIGH_WATER);
    localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(LOW_WATER);

    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] head_s;
    logic               push_req_s;
    logic               pop_ok_s;
    logic               overrun_s;
    logic               par_evt_s;
    logic               stop_evt_s;
    logic               full_s;
    logic               empty_s;
    logic [LVL_W-1:0]   level_s;

    flow_state_t        state_r;
    flow_state_t        state_next_s;
    logic               rts_r;

    uart_cfg_t          cfg_shadow_r;
    uart_cfg_t          cfg_active_r;
    logic               cfg_pending_r;
    logic               cfg_apply_s;

    logic               overrun_r;
    logic               framing_r;
    logic [CNT_W-1:0]   par_cnt_r;
    logic [CNT_W-1:0]   stop_cnt_r;

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req_s),
        .push_data (entry_s),
        .pop       (rd_en),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level_s)
    );

    // Decide whether the completing frame is queued and what error events it raises.
    always_comb begin
        push_req_s = 1'b0;
        entry_s    = {ENTRY_W{1'b0}};
        par_evt_s  = frame_valid && frame_parity_err;
        stop_evt_s = frame_valid && frame_stop_err;
        pop_ok_s   = rd_en && !empty_s;
        if (frame_valid) begin
`ifdef UART_RX_CTRL_KEEP_BAD_EN
            push_req_s = 1'b1;
            entry_s    = {frame_stop_err, frame_parity_err, frame_data};
`else
            if (!frame_stop_err) begin
                push_req_s = 1'b1;
                entry_s    = {frame_parity_err, frame_data};
            end else begin
                push_req_s = 1'b0;
            end
`endif
        end else begin
            push_req_s = 1'b0;
        end
        overrun_s = push_req_s && full_s && !pop_ok_s;
    end

    // Flow FSM next state; compares the level already updated by last cycle's push/pop.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ACCEPT: begin
                if (level_s >= HIGH_LVL) begin
                    state_next_s = THROTTLE;
                end else begin
                    state_next_s = ACCEPT;
                end
            end
            THROTTLE: begin
                if (level_s <= LOW_LVL) begin
                    state_next_s = ACCEPT;
                end else begin
                    state_next_s = THROTTLE;
                end
            end
            default: state_next_s = THROTTLE;
        endcase
    end

    // Flow state and registered RTS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= THROTTLE;
            rts_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            rts_r   <= (state_next_s == ACCEPT);
        end
    end

    assign cfg_apply_s = cfg_pending_r && !rx_busy;

    // Shadowed parity configuration, only handed to the receiver while it is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_shadow_r  <= '{parity_enable: 1'b0, parity_type: 1'b0};
            cfg_active_r  <= '{parity_enable: 1'b0, parity_type: 1'b0};
            cfg_pending_r <= 1'b0;
        end else begin
            if (cfg_apply_s) begin
                cfg_active_r <= cfg_shadow_r;
            end
            if (cfg_we) begin
                cfg_shadow_r  <= '{parity_enable: cfg_parity_enable,
                                   parity_type:   cfg_parity_type};
                cfg_pending_r <= 1'b1;
            end else if (cfg_apply_s) begin
                cfg_pending_r <= 1'b0;
            end
        end
    end

    // Sticky flags and saturating counters; a same-cycle error outranks clr_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_r  <= 1'b0;
            framing_r  <= 1'b0;
            par_cnt_r  <= {CNT_W{1'b0}};
            stop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (overrun_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end
            if (stop_evt_s) begin
                framing_r <= 1'b1;
            end else if (clr_err) begin
                framing_r <= 1'b0;
            end
            if (clr_err) begin
                par_cnt_r  <= par_evt_s  ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
                stop_cnt_r <= stop_evt_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
            end else begin
                if (par_evt_s) begin
                    par_cnt_r <= sat_inc(par_cnt_r);
                end
                if (stop_evt_s) begin
                    stop_cnt_r <= sat_inc(stop_cnt_r);
                end
            end
        end
    end

    assign rx_parity_enable = cfg_active_r.parity_enable;
    assign rx_parity_type   = cfg_active_r.parity_type;
    assign cfg_pending      = cfg_pending_r;
    assign rts_out          = rts_r;
    assign rd_data          = head_s[UART_SIZE-1:0];
    assign rd_perr          = head_s[UART_SIZE];
`ifdef UART_RX_CTRL_KEEP_BAD_EN
    assign rd_serr          = head_s[UART_SIZE+1];
`endif
    assign rd_valid         = !empty_s;
    assign level            = level_s;
    assign overrun_err      = overrun_r;
    assign framing_err      = framing_r;
    assign parity_err_cnt   = par_cnt_r;
    assign stop_err_cnt     = stop_cnt_r;

endmodule
